// File: rtl/seq_mem_pkg.sv
// Shared types and helpers for the pipelined sequential memory.
package seq_mem_pkg;

  // Read-during-write result selection
  typedef enum logic [0:0] {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  localparam int unsigned MAX_READ_LAT = 4;

  // Number of write-mask lanes in a data word
  function automatic int unsigned num_lanes(input int unsigned width, input int unsigned byte_w);
    return width / byte_w;
  endfunction

endpackage

// File: rtl/seq_mem_rd_pipe.sv
// Read-data delay line: {valid, oob, data} shifted one stage per cycle.
// Data registers load only behind a valid bit, so the last stage holds the
// most recently completed read until the next one arrives.
module seq_mem_rd_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_oob,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_oob,
  output logic [WIDTH-1:0] out_data
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] oob_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  // Shift stages; reset drops everything in flight and zeroes the data
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      oob_q   <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      oob_q[0]   <= in_valid & in_oob;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        valid_q[i] <= valid_q[i-1];
        oob_q[i]   <= oob_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_oob   = oob_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

endmodule

// File: rtl/seq_mem_d1_pipe.sv
// Single-port sequential memory with byte-masked writes, pipelined reads,
// selectable read-during-write result and hardware out-of-bounds detection.
module seq_mem_d1_pipe
  import seq_mem_pkg::*;
#(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned SIZE      = 64,
  parameter  int unsigned IDX_SIZE  = 8,
  parameter  int unsigned BYTE_W    = 8,
  parameter  int unsigned READ_LAT  = 1,
  parameter  int unsigned RDW_MODE  = 0,
  localparam int unsigned NUM_LANES = num_lanes(WIDTH, BYTE_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_SIZE-1:0]  addr0,
  input  logic                 read_en,
  output logic [WIDTH-1:0]     out,
  output logic                 read_done,
  input  logic [WIDTH-1:0]     in,
  input  logic                 write_en,
  input  logic [NUM_LANES-1:0] write_mask,
  output logic                 write_done,
  output logic                 oob_err
);

  localparam int unsigned ADDR_W      = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam bit          RDW_NEW_SEL = (RDW_MODE == 32'(RDW_NEW));

  (* ram_style = "ultra" *) logic [WIDTH-1:0] mem [SIZE];

  logic [ADDR_W-1:0] idx_c;
  logic              oob_c;
  logic [WIDTH-1:0]  merged_c;
  logic [WIDTH-1:0]  rd_word_c;

  logic              s0_valid;
  logic              s0_oob;
  logic [WIDTH-1:0]  s0_data;

  logic              rd_valid;
  logic              rd_oob;
  logic [WIDTH-1:0]  rd_data;

  logic              wr_done_q;
  logic              wr_oob_q;

  // IDX_SIZE is at most 32, so the widened compare is exact
  assign idx_c = addr0[ADDR_W-1:0];
  assign oob_c = (32'(addr0) >= SIZE);

  // Current word with the masked lanes replaced by write data
  always_comb begin
    merged_c = mem[idx_c];
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (write_mask[i]) begin
        merged_c[i*BYTE_W +: BYTE_W] = in[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read word selection: zero when out of bounds, otherwise old or merged
  always_comb begin
    rd_word_c = mem[idx_c];
    if (oob_c) begin
      rd_word_c = '0;
    end else if (RDW_NEW_SEL && write_en) begin
      rd_word_c = merged_c;
    end
  end

  // Byte-lane array write; out-of-bounds writes are dropped
  always_ff @(posedge clk) begin
    if (!reset && write_en && !oob_c) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (write_mask[i]) begin
          mem[idx_c][i*BYTE_W +: BYTE_W] <= in[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Stage 0: array read register
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_oob   <= 1'b0;
      s0_data  <= '0;
    end else begin
      s0_valid <= read_en;
      s0_oob   <= read_en & oob_c;
      if (read_en) begin
        s0_data <= rd_word_c;
      end
    end
  end

  // Write completion and its out-of-bounds flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_done_q <= 1'b0;
      wr_oob_q  <= 1'b0;
    end else begin
      wr_done_q <= write_en;
      wr_oob_q  <= write_en & oob_c;
    end
  end

  // Remaining read latency beyond stage 0
  if (READ_LAT == 1) begin : g_no_pipe
    assign rd_valid = s0_valid;
    assign rd_oob   = s0_oob;
    assign rd_data  = s0_data;
  end else begin : g_pipe
    seq_mem_rd_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (READ_LAT - 1)
    ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (s0_valid),
      .in_oob    (s0_oob),
      .in_data   (s0_data),
      .out_valid (rd_valid),
      .out_oob   (rd_oob),
      .out_data  (rd_data)
    );
  end

  assign out        = rd_data;
  assign read_done  = rd_valid;
  assign write_done = wr_done_q;
  // Both sources are flops; a coincident read and write error merge into one pulse
  assign oob_err    = (rd_valid & rd_oob) | wr_oob_q;

  // Parameter sanity checks for simulation
  always_ff @(posedge clk) begin
    assert (WIDTH % BYTE_W == 0);
    assert (READ_LAT >= 1 && READ_LAT <= MAX_READ_LAT);
    assert (IDX_SIZE <= 32);
    assert ((64'(1) << IDX_SIZE) >= 64'(SIZE));
  end

endmodule

// File: tb/tb_seq_mem_d1_pipe.sv
// Directed bench: five memories with different READ_LAT / RDW_MODE share one
// stimulus stream; each cycle every output is compared to expected values.
module tb_seq_mem_d1_pipe;

  localparam int unsigned N     = 5;
  localparam int unsigned SLOTS = 8;
  localparam int unsigned LAT_TAB  [N] = '{1, 2, 3, 3, 4};
  localparam int unsigned MODE_TAB [N] = '{0, 0, 0, 1, 0};

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr0;
  logic        read_en;
  logic        write_en;
  logic [31:0] in;
  logic [3:0]  write_mask;

  logic [31:0] out_w     [N];
  logic        rd_done_w [N];
  logic        wr_done_w [N];
  logic        oob_w     [N];

  // Expected completions, indexed by edge number modulo SLOTS
  logic        exp_rd_v [N][SLOTS];
  logic [31:0] exp_rd_d [N][SLOTS];
  logic        exp_rd_o [N][SLOTS];
  logic        exp_wr_v [SLOTS];
  logic        exp_wr_o [SLOTS];
  logic [31:0] last_out [N];

  int cyc;
  int checks;
  int errors;

  always #5 clk = ~clk;

  for (genvar g = 0; g < int'(N); g++) begin : g_dut
    seq_mem_d1_pipe #(
      .WIDTH    (32),
      .SIZE     (64),
      .IDX_SIZE (8),
      .BYTE_W   (8),
      .READ_LAT (LAT_TAB[g]),
      .RDW_MODE (MODE_TAB[g])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .addr0      (addr0),
      .read_en    (read_en),
      .out        (out_w[g]),
      .read_done  (rd_done_w[g]),
      .in         (in),
      .write_en   (write_en),
      .write_mask (write_mask),
      .write_done (wr_done_w[g]),
      .oob_err    (oob_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic flush_all();
    for (int g = 0; g < int'(N); g++) begin
      for (int s = 0; s < int'(SLOTS); s++) begin
        exp_rd_v[g][s] = 1'b0;
        exp_rd_d[g][s] = '0;
        exp_rd_o[g][s] = 1'b0;
      end
      last_out[g] = '0;
    end
    for (int s = 0; s < int'(SLOTS); s++) begin
      exp_wr_v[s] = 1'b0;
      exp_wr_o[s] = 1'b0;
    end
  endtask

  // Advance one edge, then compare every instance's outputs
  task automatic tick();
    int  slot;
    logic ev;
    logic eo;
    @(posedge clk);
    cyc++;
    #1;
    slot = cyc % int'(SLOTS);
    if (reset) flush_all();
    for (int g = 0; g < int'(N); g++) begin
      ev = exp_rd_v[g][slot];
      eo = (ev & exp_rd_o[g][slot]) | (exp_wr_v[slot] & exp_wr_o[slot]);
      if (ev) last_out[g] = exp_rd_d[g][slot];
      check($sformatf("d%0d_read_done", g), 32'(rd_done_w[g]), 32'(ev));
      check($sformatf("d%0d_out", g), out_w[g], last_out[g]);
      check($sformatf("d%0d_write_done", g), 32'(wr_done_w[g]), 32'(exp_wr_v[slot]));
      check($sformatf("d%0d_oob_err", g), 32'(oob_w[g]), 32'(eo));
      exp_rd_v[g][slot] = 1'b0;
    end
    exp_wr_v[slot] = 1'b0;
  endtask

  // Present one request for a single edge; exp_old/exp_new are the read
  // results for RDW_MODE 0 and 1 instances respectively
  task automatic op(input logic rd, input logic wr, input logic [7:0] a,
                    input logic [31:0] d, input logic [3:0] m,
                    input logic [31:0] exp_old, input logic [31:0] exp_new);
    int due;
    int s;
    addr0      = a;
    read_en    = rd;
    write_en   = wr;
    in         = d;
    write_mask = m;
    due = cyc + 1;
    if (rd) begin
      for (int g = 0; g < int'(N); g++) begin
        s = (due + int'(LAT_TAB[g]) - 1) % int'(SLOTS);
        exp_rd_v[g][s] = 1'b1;
        exp_rd_d[g][s] = (MODE_TAB[g] == 1) ? exp_new : exp_old;
        exp_rd_o[g][s] = (a >= 8'd64);
      end
    end
    if (wr) begin
      s = due % int'(SLOTS);
      exp_wr_v[s] = 1'b1;
      exp_wr_o[s] = (a >= 8'd64);
    end
    tick();
    read_en  = 1'b0;
    write_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    addr0      = '0;
    read_en    = 1'b0;
    write_en   = 1'b0;
    in         = '0;
    write_mask = '0;
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    flush_all();

    do_reset(2);

    // Full-word write, read back, then hold across idle cycles
    op(1'b0, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF, '0, '0);
    op(1'b1, 1'b0, 8'd5, '0, 4'h0, 32'hDEADBEEF, 32'hDEADBEEF);
    idle(10);

    // Empty mask still completes and leaves memory alone
    op(1'b0, 1'b1, 8'd5, 32'h0, 4'h0, '0, '0);
    op(1'b1, 1'b0, 8'd5, '0, 4'h0, 32'hDEADBEEF, 32'hDEADBEEF);
    idle(4);

    // Partial write over a known background
    op(1'b0, 1'b1, 8'd2, 32'hAAAAAAAA, 4'hF, '0, '0);
    op(1'b0, 1'b1, 8'd2, 32'h11223344, 4'b0101, '0, '0);
    op(1'b1, 1'b0, 8'd2, '0, 4'h0, 32'hAA22AA44, 32'hAA22AA44);
    idle(4);

    // Read-during-write: old data vs merged data
    op(1'b0, 1'b1, 8'd7, 32'h1, 4'hF, '0, '0);
    op(1'b1, 1'b1, 8'd7, 32'h2, 4'hF, 32'h1, 32'h2);
    op(1'b1, 1'b0, 8'd7, '0, 4'h0, 32'h2, 32'h2);
    idle(4);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 8'(i), 32'(10 + i), 4'hF, '0, '0);
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 8'(i), '0, 4'h0, 32'(10 + i), 32'(10 + i));
    idle(5);

    // Reset in the middle of a burst drops in-flight reads
    op(1'b1, 1'b0, 8'd0, '0, 4'h0, 32'd10, 32'd10);
    op(1'b1, 1'b0, 8'd1, '0, 4'h0, 32'd11, 32'd11);
    do_reset(1);
    idle(6);

    // Out-of-bounds write, in-bounds read unaffected, out-of-bounds read
    op(1'b0, 1'b1, 8'd64, 32'h0000FFFF, 4'hF, '0, '0);
    op(1'b1, 1'b0, 8'd0, '0, 4'h0, 32'd10, 32'd10);
    op(1'b1, 1'b0, 8'd70, '0, 4'h0, 32'h0, 32'h0);
    idle(4);
    op(1'b1, 1'b0, 8'd3, '0, 4'h0, 32'd13, 32'd13);
    op(1'b1, 1'b1, 8'd80, 32'h1234, 4'hF, 32'h0, 32'h0);
    idle(6);
    op(1'b1, 1'b0, 8'd255, '0, 4'h0, 32'h0, 32'h0);
    idle(5);

    // Read the cycle after a write sees it; a later write leaves out alone
    op(1'b0, 1'b1, 8'd9, 32'h99, 4'hF, '0, '0);
    op(1'b1, 1'b0, 8'd9, '0, 4'h0, 32'h99, 32'h99);
    op(1'b0, 1'b1, 8'd9, 32'h55, 4'hF, '0, '0);
    idle(6);
    op(1'b1, 1'b0, 8'd9, '0, 4'h0, 32'h55, 32'h55);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mem_d1_pipe.md
Name: seq_mem_d1_pipe

Overview:
- Single-port sequential memory with byte-masked writes and a configurable, fully pipelined read latency.
- Simultaneous read and write are legal, with a selectable read-during-write result.
- Out-of-bounds accesses are detected in hardware rather than only in simulation.
- Drop-in next generation of the d1 sequential memory, for Calyx-lowered designs that need wider data, partial writes, or deeper read pipelines for timing.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of BYTE_W.
- SIZE, 64, number of words.
- IDX_SIZE, 8, address width in bits.
- BYTE_W, 8, bits per write-mask lane; NUM_LANES = WIDTH/BYTE_W.
- READ_LAT, 1, cycles from read_en to read_done; legal range 1..4.
- RDW_MODE, 0, read-during-write to the same address: 0 = old data, 1 = new (merged) data.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- addr0  input  IDX_SIZE  word address, shared by read and write.
- read_en  input  1  read request, accepted every cycle it is high.
- out  output  WIDTH  registered read data.
- read_done  output  1  pulse: out updated this cycle.
- in  input  WIDTH  write data.
- write_en  input  1  write request.
- write_mask  input  NUM_LANES  per-lane write enable; lane i covers bits [i*BYTE_W +: BYTE_W].
- write_done  output  1  pulse, one cycle after an accepted write.
- oob_err  output  1  pulse, aligned with the read_done or write_done of an out-of-bounds access.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: out = 0, read_done = 0, write_done = 0, oob_err = 0.
  - All read-pipeline valid bits are cleared, so in-flight reads are dropped and never raise read_done.
  - Memory contents are not cleared.
  - Requests presented in the reset cycle are ignored.
- Read:
  - read_en high at edge T captures addr0.
  - read_done is high for exactly the cycle after edge T+READ_LAT-1, i.e. READ_LAT cycles later; out changes only at that same edge.
  - Throughput is one read per cycle; back-to-back reads produce back-to-back read_done pulses in order.
  - out holds its last value until the next read completes. A write alone never clobbers out.
- Write:
  - write_en high at edge T updates lanes whose write_mask bit is 1; other lanes keep their value.
  - write_done pulses in cycle T+1.
  - write_mask = 0 still pulses write_done and leaves memory unchanged.
- Simultaneous read_en and write_en (same address by construction):
  - RDW_MODE 0: the read returns pre-write contents.
  - RDW_MODE 1: the read returns post-write merged contents.
  - Both done pulses occur at their normal latencies.
- Read-after-write ordering: a read issued at T+1 or later after a write at T always sees the write, for any READ_LAT.
- Out of bounds (addr0 >= SIZE):
  - Write is suppressed; write_done and oob_err pulse together.
  - Read completes normally but delivers out = 0; oob_err pulses with read_done.
  - If a read and a write are both out of bounds in the same cycle, oob_err pulses in each corresponding done cycle. With READ_LAT = 1 these are the same cycle, and oob_err is a single pulse.
- Pipelining: stage 0 is the array read register; stages 1..READ_LAT-1 are plain registers carrying {valid, oob, data}.
- Simulation-only assertions: WIDTH % BYTE_W == 0; READ_LAT in 1..4; 2**IDX_SIZE >= SIZE.
- Storage: the array carries ram_style = "ultra".

Decomposition:
- Package seq_mem_pkg:
  - rdw_mode_e enum {RDW_OLD = 0, RDW_NEW = 1}.
  - MAX_READ_LAT = 4.
  - Function num_lanes(WIDTH, BYTE_W).
- Sub-module seq_mem_rd_pipe: parameterised by WIDTH and STAGES; shift pipeline of {valid, oob, data} with synchronous clear. Instantiated with STAGES = READ_LAT-1 and bypassed when READ_LAT = 1.
- Top level holds the array, the mask merge, the RDW mux, the OOB compare, and the done/err logic.

Test Plan:
- READ_LAT = 3. Write 0xDEADBEEF to addr 5 with mask 4'hF, then read addr 5 at T → read_done and out = 0xDEADBEEF at T+3; out holds for 10 idle cycles.
- Mask 4'b0101 writing 0x11223344 over 0xAAAAAAAA at addr 2, then read → 0xAA22AA44.
- Simultaneous read and write at addr 7 (old 0x1, new 0x2): RDW_MODE 0 → out = 0x1, RDW_MODE 1 → out = 0x2; both done pulses occur.
- READ_LAT = 2. Reads of addr 0,1,2,3 on consecutive cycles (preloaded 10,11,12,13) → four consecutive read_done pulses with out = 10,11,12,13. Reset asserted mid-burst → no further read_done, out = 0.
- Write 0xFFFF to addr 64 (SIZE = 64) → write_done and oob_err pulse, addr 0 unchanged; read addr 70 → out = 0, oob_err pulses with read_done.
- A write at T to addr 9 followed by a read of addr 9 at T+1 (READ_LAT = 4) returns the new data. write_en alone after a read leaves out unchanged.
